chain_add_sequencer: RTL
========================

// Module: chain_add_sequencer
// PURPOSE
//  Hardware driver for the ALU's add-immediate path. Accepts an operand stream over a valid/ready
//  handshake and issues each operand to an external alu as imm, with data1 = running sum.
//  Captures alu result/overflow and returns every partial sum on an output stream.
//  Sits between a data source (FIFO/loader) and one alu instance; replaces the software chain-add loop.
// PARAMETERS
//  IN_W     8   operand width; zero-extended to 32 bits for imm (1..32)
//  ALU_LAT  1   cycles from imm/data1 drive to alu result being sampled (>=1)
//  CNT_W    16  width of operand counter within the current chain
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  clr          in   1       sync clear: acc<=0, count<=0, FSM->IDLE, drops in-flight op
//  in_valid     in   1       operand valid
//  in_ready     out  1       operand accepted when in_valid&in_ready
//  in_data      in   IN_W    operand, unsigned
//  in_last      in   1       final operand of chain
//  alu_src      out  1       constant 1 (immediate operand)
//  alu_ctrl     out  4       constant 4'b0000 (ADD)
//  alu_data1    out  32      running sum acc
//  alu_imm      out  32      {zeros, operand}
//  alu_result   in   32      alu result
//  alu_overflow in   1       alu signed overflow
//  sum_valid    out  1       partial sum valid
//  sum_ready    in   1       partial sum accepted when sum_valid&sum_ready
//  sum_data     out  32      partial sum
//  sum_last     out  1       sum_data is the final sum of chain
//  count        out  CNT_W   operands accepted in current chain
//  err          out  1       overflow error (CHAIN_ADD_OVF_STOP_EN only; else tied 0)
// BEHAVIOUR
//  Reset: FSM=IDLE; acc, alu_imm, sum_data, count = 0; in_ready=1, sum_valid=0, sum_last=0, err=0.
//  FSM: IDLE -> ISSUE -> OUT -> IDLE; ERR added with macro.
//  IDLE: in_ready=1. On accept, register imm=zext(in_data) and last_q=in_last; count+1; go ISSUE.
//  ISSUE: in_ready=0; wait counter runs ALU_LAT cycles.
//   On the ALU_LAT-th edge: acc<=alu_result, sum_data<=alu_result, sum_last<=last_q; go OUT.
//  OUT: sum_valid=1, sum_data/sum_last held stable until handshake.
//   On sum_ready: go IDLE. If sum_last, acc<=0 and count<=0 (new chain).
//  Throughput: one operand per ALU_LAT+2 cycles; no overlap of operations.
//  Arithmetic: 32-bit modulo; wrap-around is not an error without macro.
//  count saturates at all-ones; it never wraps.
//  clr has priority over any handshake in the same cycle; sum_valid drops the next cycle.
//  rst_n low mid-operation: immediate return to reset values; the in-flight operand is lost.
//  in_valid held without ready: in_data/in_last must be held stable by the source.
//  alu_src and alu_ctrl are constant in all states, including reset.
// CONFIGURATION
//  CHAIN_ADD_OVF_STOP_EN defined: alu_overflow sampled with result.
//   If alu_overflow=1: acc is NOT updated, err<=1, FSM->ERR; in_ready=0, sum_valid=0.
//   Only clr or rst_n leaves ERR: err<=0, acc<=0, count<=0.
//  Not defined: alu_overflow ignored, err tied 0, ERR state absent.
// STRUCTURE
//  Shared package chain_add_pkg:
//   - FSM state enum
//   - ALU_CTRL_ADD = 4'b0000
//   - ALU_SRC_IMM = 1'b1
//   - DATA_W = 32
//  No sub-module; FSM, wait counter, and acc in one module. alu instantiated by the parent.
// TESTING (bench instantiates the real alu, ALU_LAT=1, IN_W=8)
//  1 Chain 3,5,7 (7 with in_last) -> sums 3, 8, 15; sum_last only on 15; count=3 then 0.
//   Next chain 4 -> sum 4.
//  2 sum_ready held low 5 cycles on sum 8 -> sum_data stable at 8, in_ready=0 throughout.
//   No operand lost.
//  3 IN_W=32: 0x7FFFFFFF then 1 -> with macro: err=1, acc stays 0x7FFFFFFF, no sum emitted.
//   Without macro: sum 0x80000000, err=0.
//  4 clr asserted during ISSUE of operand 9 after sum 10 -> no sum emitted.
//   acc=0, count=0; next operand 2 -> sum 2.
//  5 rst_n pulsed low in OUT state -> all outputs at reset values asynchronously.
//   Chain 1,1 restarts -> sums 1, 2.
//  6 255 x 255 (IN_W=8, in_last on 255th) -> final sum 65025, sum_last=1, count=255.

Source files
------------

// File: rtl/chain_add_sequencer_pkg.sv
// Shared types/constants for the chain-add sequencer; no logic, no latency.
// Optional ERR state exists only when CHAIN_ADD_OVF_STOP_EN is defined.
package chain_add_pkg;

    localparam int          DATA_W       = 32;
    localparam logic [3:0]  ALU_CTRL_ADD = 4'b0000;
    localparam logic        ALU_SRC_IMM  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
`ifdef CHAIN_ADD_OVF_STOP_EN
        ST_OUT   = 2'd2,
        ST_ERR   = 2'd3
`else
        ST_OUT   = 2'd2
`endif
    } state_t;

endpackage

// File: rtl/chain_add_sequencer_if.sv
// Operand stream, partial-sum stream and ALU drive bundle; master = source/ALU side, slave = sequencer.
// Pure wiring: no latency, valid/ready backpressure on both streams.
interface chain_add_sequencer_if #(
    parameter int IN_W  = 8,
    parameter int CNT_W = 16
);
    logic                          in_valid;
    logic                          in_ready;
    logic [IN_W-1:0]               in_data;
    logic                          in_last;

    logic                          alu_src;
    logic [3:0]                    alu_ctrl;
    logic [chain_add_pkg::DATA_W-1:0] alu_data1;
    logic [chain_add_pkg::DATA_W-1:0] alu_imm;
    logic [chain_add_pkg::DATA_W-1:0] alu_result;
    logic                          alu_overflow;

    logic                          sum_valid;
    logic                          sum_ready;
    logic [chain_add_pkg::DATA_W-1:0] sum_data;
    logic                          sum_last;

    logic [CNT_W-1:0]              count;
    logic                          err;

    modport master (
        output in_valid, in_data, in_last, sum_ready, alu_result, alu_overflow,
        input  in_ready, sum_valid, sum_data, sum_last,
               alu_src, alu_ctrl, alu_data1, alu_imm, count, err
    );

    modport slave (
        input  in_valid, in_data, in_last, sum_ready, alu_result, alu_overflow,
        output in_ready, sum_valid, sum_data, sum_last,
               alu_src, alu_ctrl, alu_data1, alu_imm, count, err
    );
endinterface

// File: rtl/chain_add_sequencer.sv
// Drives an external ALU add-immediate to accumulate an operand chain; one operand per ALU_LAT+2 cycles,
// sum held until sum_ready, in_ready low while busy. CHAIN_ADD_OVF_STOP_EN enables stop-on-overflow.
module chain_add_sequencer
    import chain_add_pkg::*;
#(
    parameter int IN_W    = 8,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    chain_add_sequencer_if.slave  bus
);

    localparam int WAIT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   sum_q;
    logic                last_q;
    logic                sum_last_q;
    logic [CNT_W-1:0]    cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                in_fire;
    logic                out_fire;
    logic                wait_done;

    assign in_fire   = bus.in_valid & bus.in_ready;
    assign out_fire  = bus.sum_valid & bus.sum_ready;
    assign wait_done = (state == ST_ISSUE) && (wait_cnt == WAIT_W'(ALU_LAT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (in_fire)  state_nxt = ST_ISSUE;
`ifdef CHAIN_ADD_OVF_STOP_EN
                ST_ISSUE: if (wait_done) state_nxt = bus.alu_overflow ? ST_ERR : ST_OUT;
                ST_ERR:   state_nxt = ST_ERR;
`else
                ST_ISSUE: if (wait_done) state_nxt = ST_OUT;
`endif
                ST_OUT:   if (out_fire) state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // clr masks in_ready so a same-cycle handshake is never seen as accepted
    always_comb begin
        bus.in_ready  = (state == ST_IDLE) && !clr;
        bus.sum_valid = (state == ST_OUT);
    end

    assign bus.alu_src   = ALU_SRC_IMM;
    assign bus.alu_ctrl  = ALU_CTRL_ADD;
    assign bus.alu_data1 = acc;
    assign bus.alu_imm   = imm;
    assign bus.sum_data  = sum_q;
    assign bus.sum_last  = sum_last_q;
    assign bus.count     = cnt;

`ifdef CHAIN_ADD_OVF_STOP_EN
    logic err_q;
    assign bus.err = err_q;
`else
    logic unused_ovf;
    assign unused_ovf = bus.alu_overflow;
    assign bus.err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            imm        <= '0;
            sum_q      <= '0;
            last_q     <= 1'b0;
            sum_last_q <= 1'b0;
            cnt        <= '0;
            wait_cnt   <= '0;
`ifdef CHAIN_ADD_OVF_STOP_EN
            err_q      <= 1'b0;
`endif
        end else if (clr) begin
            acc      <= '0;
            cnt      <= '0;
            wait_cnt <= '0;
`ifdef CHAIN_ADD_OVF_STOP_EN
            err_q    <= 1'b0;
`endif
        end else begin
            if (in_fire) begin
                imm      <= DATA_W'(bus.in_data);
                last_q   <= bus.in_last;
                wait_cnt <= '0;
                if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
            end
            if ((state == ST_ISSUE) && !wait_done) wait_cnt <= wait_cnt + WAIT_W'(1);
            if (wait_done) begin
`ifdef CHAIN_ADD_OVF_STOP_EN
                if (bus.alu_overflow) begin
                    err_q <= 1'b1;
                end else begin
                    acc        <= bus.alu_result;
                    sum_q      <= bus.alu_result;
                    sum_last_q <= last_q;
                end
`else
                acc        <= bus.alu_result;
                sum_q      <= bus.alu_result;
                sum_last_q <= last_q;
`endif
            end
            // the final sum of a chain leaves the accumulator ready for the next chain
            if (out_fire && sum_last_q) begin
                acc <= '0;
                cnt <= '0;
            end
        end
    end

endmodule
